mem_bus_ctrl: RTL
=================

# mem_bus_ctrl

Sequential memory-access controller directly downstream of the memory-request preparation stage. It takes the prepared word address, replicated write data, byte strobe and illegal flag, and runs the request on a valid/ready data bus. It stalls the pipeline until the response arrives, then aligns and sign/zero-extends load data for writeback. Illegal accesses and bus errors are reported as a single-cycle fault without touching the bus.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255 — response watchdog limit in cycles; only used when the watchdog is compiled in.

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset; synchronous, active-high
- mem_read_i  in  1  stage holds a load
- mem_write_i  in  1  stage holds a store
- mem_width_i  in  mem_width_e  BYTE/HALF/WORD
- mem_unsigned_i  in  1  zero-extend load (LBU/LHU)
- mem_byte_idx_i  in  2  original address bits [1:0]
- mem_word_addr_i  in  32  word-aligned address from prep stage
- mem_write_data_i  in  32  replicated write data
- mem_strobe_i  in  4  byte strobe; zero for loads
- mem_illegal_i  in  1  misaligned or bad-width access
- stall_o  out  1  hold the pipeline stage
- load_data_o  out  32  extended load result
- load_valid_o  out  1  one-cycle pulse: load_data_o is valid
- fault_o  out  1  one-cycle pulse: access failed
- fault_bus_o  out  1  qualifies fault_o: 1 = bus error/timeout, 0 = illegal access
- bus_valid_o  out  1  request valid
- bus_ready_i  in  1  request accepted
- bus_we_o  out  1  1 = write
- bus_addr_o  out  32  word address
- bus_wdata_o  out  32  write data
- bus_strobe_o  out  4  byte enables
- bus_rvalid_i  in  1  response valid; reads and writes both respond
- bus_rdata_i  in  32  read data
- bus_err_i  in  1  response carries an error; sampled with bus_rvalid_i

## Operation
- States: IDLE, REQ, RESP, DONE.
- Request present: mem_read_i | mem_write_i.
- IDLE, request present, mem_illegal_i=1:
  - fault_o=1 and fault_bus_o=0, combinationally.
  - stall_o=0; state stays IDLE; no bus activity.
- IDLE, legal request:
  - stall_o=1 combinationally.
  - Latch addr, wdata, strobe, we=mem_write_i, width, unsigned flag and byte_idx.
  - Next state REQ.
- REQ:
  - bus_valid_o=1 with the latched fields.
  - On bus_ready_i, go to RESP.
  - Fields stay stable while valid is high and ready is low.
- RESP:
  - On bus_rvalid_i, capture rdata and err; go to DONE.
  - If rvalid and ready coincide with the REQ→RESP handoff, the response is taken in the RESP cycle, never the REQ cycle.
- DONE:
  - stall_o=0.
  - Error captured: fault_o=1 and fault_bus_o=1; load_valid_o=0.
  - Otherwise, for a load: load_valid_o=1. A store produces no pulse.
  - Next state IDLE unconditionally. IDLE therefore sees the advanced stage's inputs next cycle, so a request is never re-issued.
- stall_o is 1 in REQ and RESP.
- Load extraction: shift captured rdata right by 8·byte_idx, then by width:
  - BYTE: bits [7:0], extended from bit 7.
  - HALF: bits [15:0], extended from bit 15.
  - WORD: passed through unchanged.
  - Extension is zero when unsigned, sign otherwise.
- bus_rvalid_i in IDLE or REQ: ignored. Stale responses are dropped.
- Reset:
  - State IDLE; the latched request is cleared.
  - All outputs 0: bus_valid_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_strobe_o, stall_o, load_data_o, load_valid_o, fault_o, fault_bus_o.
  - Reset mid-transaction abandons it; bus_valid_o drops on the next edge.

## Timing
- Best case, ready and rvalid each on their first possible cycle:
  - cycle 0: IDLE, stall=1.
  - cycle 1: REQ, valid=1, ready=1.
  - cycle 2: RESP, rvalid=1.
  - cycle 3: DONE, load_valid=1, stall=0.
- Best case totals: 4 cycles per access; stall high for 3 cycles.
- Each ready-low cycle in REQ and each rvalid-low cycle in RESP adds exactly one cycle.
- An illegal access completes in 0 extra cycles with a fault in the same cycle.
- load_data_o is registered at capture and holds until the next capture.

## Configuration
- MEM_BUS_TIMEOUT_EN defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or RESP.
  - On reaching TIMEOUT_CYCLES without completion, go to DONE with the error flag set: fault_o=1, fault_bus_o=1.
  - bus_valid_o drops with the transition.
  - A response arriving in the same cycle as the timeout wins.
- MEM_BUS_TIMEOUT_EN undefined: no counter; the block waits indefinitely.

## Test plan
- LB at 0x1003, rdata=0x80AA_BB11, ready/rvalid immediate → bus_addr_o=0x1000, load_data_o=0xFFFF_FF80 in cycle 3; stall high in cycles 0–2.
- LHU at 0x2002, rdata=0xBEEF_1234, ready held low 3 cycles → load_data_o=0x0000_BEEF in cycle 6; bus fields stable throughout REQ.
- SW of 0xDEAD_BEEF with strobe 4'hF → bus_we_o=1, bus_wdata_o=0xDEAD_BEEF, no load_valid_o, stall released in DONE.
- Illegal LW (mem_illegal_i=1) → fault_o=1 and fault_bus_o=0 in the same cycle, stall_o=0, bus_valid_o never asserted.
- Response with bus_err_i=1 → fault_o=1 and fault_bus_o=1 in DONE, load_valid_o=0; separately, rst_i in RESP → next cycle IDLE with all outputs 0, and a late rvalid is ignored.
- MEM_BUS_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ready → fault_o=1 and fault_bus_o=1 after 4 cycles in REQ, bus_valid_o=0 in DONE.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// Memory-access controller: runs one prepared load/store on a valid/ready data bus,
// stalls the stage until the response, then extends load data. Optional watchdog: MEM_BUS_TIMEOUT_EN.
package mem_bus_pkg;
    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_width_e;
endpackage

module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  mem_width_e  mem_width_i,
    input  logic        mem_unsigned_i,
    input  logic [1:0]  mem_byte_idx_i,
    input  logic [31:0] mem_word_addr_i,
    input  logic [31:0] mem_write_data_i,
    input  logic [3:0]  mem_strobe_i,
    input  logic        mem_illegal_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        fault_o,
    output logic        fault_bus_o,
    output logic        bus_valid_o,
    input  logic        bus_ready_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_strobe_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e      r_state;
    logic        r_we;
    logic        r_uns;
    logic        r_err;
    mem_width_e  r_width;
    logic [1:0]  r_bidx;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_strobe;
    logic [31:0] r_load_data;

    logic        w_req;
    logic        w_start;
    logic        w_timeout;
    logic [31:0] w_shifted;
    logic [31:0] w_ext;

    assign w_req   = mem_read_i | mem_write_i;
    assign w_start = (r_state == S_IDLE) && w_req && !mem_illegal_i;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;

    // The counter can sit one past the limit when ready arrives on the last REQ cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
        end else if (r_state == S_REQ || r_state == S_RESP) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_cnt >= CW'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_shifted = bus_rdata_i >> {r_bidx, 3'b000};
        case (r_width)
            MEM_BYTE: w_ext = {{24{~r_uns & w_shifted[7]}}, w_shifted[7:0]};
            MEM_HALF: w_ext = {{16{~r_uns & w_shifted[15]}}, w_shifted[15:0]};
            default:  w_ext = w_shifted;
        endcase
    end

    // Responses are only looked at in RESP, so one coinciding with the REQ handoff
    // is taken a cycle later and anything arriving in IDLE/REQ is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_uns       <= 1'b0;
            r_err       <= 1'b0;
            r_width     <= MEM_BYTE;
            r_bidx      <= 2'b00;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_strobe    <= '0;
            r_load_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_we     <= mem_write_i;
                        r_uns    <= mem_unsigned_i;
                        r_width  <= mem_width_i;
                        r_bidx   <= mem_byte_idx_i;
                        r_addr   <= mem_word_addr_i;
                        r_wdata  <= mem_write_data_i;
                        r_strobe <= mem_strobe_i;
                        r_err    <= 1'b0;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus_ready_i) begin
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_RESP: begin
                    if (bus_rvalid_i) begin
                        r_err <= bus_err_i;
                        if (!r_we) begin
                            r_load_data <= w_ext;
                        end
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_o      = w_start || (r_state == S_REQ) || (r_state == S_RESP);
    assign fault_o      = ((r_state == S_IDLE) && w_req && mem_illegal_i) ||
                          ((r_state == S_DONE) && r_err);
    assign fault_bus_o  = (r_state == S_DONE) && r_err;
    assign load_valid_o = (r_state == S_DONE) && !r_err && !r_we;
    assign load_data_o  = r_load_data;
    assign bus_valid_o  = (r_state == S_REQ);
    assign bus_we_o     = r_we;
    assign bus_addr_o   = r_addr;
    assign bus_wdata_o  = r_wdata;
    assign bus_strobe_o = r_strobe;

endmodule
